// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer behind the UART receiver: sync hunt, DEPTH-byte assembly, valid/ready output.
// Define UART_FRAME_CSUM_EN to require a trailing modulo-2^WIDTH checksum byte per frame.
module uart_rx_frame_ctrl #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DEPTH       = 4,
    parameter logic [WIDTH-1:0] SYNC_BYTE   = 8'hA5,
    parameter int unsigned      TIMEOUT_CYC = 1000
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   i_rx_valid,
    input  logic [WIDTH-1:0]       i_rx_data,
    output logic                   o_frm_valid,
    input  logic                   i_frm_ready,
    output logic [DEPTH*WIDTH-1:0] o_frm_data,
    output logic                   o_busy,
    output logic                   o_err_timeout,
    output logic                   o_err_csum,
    output logic [7:0]             o_drop_cnt
);

    // state   | meaning
    // IDLE    | hunting for SYNC_BYTE
    // COLLECT | storing payload bytes at r_idx
    // CSUM    | waiting for the trailing checksum byte (checksum build only)
    // HOLD    | frame presented, waiting for i_frm_ready

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
`ifdef UART_FRAME_CSUM_EN
        , ST_CSUM  = 2'd3
`endif
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic [TMO_W-1:0]       r_tmo_cnt;
    logic [TMO_W-1:0]       w_tmo_nxt;
    logic [DEPTH*WIDTH-1:0] r_frm_data;
    logic [7:0]             r_drop_cnt;
    logic                   r_err_timeout;
    logic                   r_err_csum;
    logic                   w_store;
    logic                   w_last;
    logic                   w_tmo_hit;
    logic                   w_timeout;
    logic                   w_csum_bad;
    logic                   w_drop;
`ifdef UART_FRAME_CSUM_EN
    logic [WIDTH-1:0]       r_sum;
`endif

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_store     = 1'b0;
        w_timeout   = 1'b0;
        w_csum_bad  = 1'b0;
        w_drop      = 1'b0;
        w_tmo_nxt   = '0;
        w_last      = (r_idx == IDX_W'(DEPTH - 1));
        w_tmo_hit   = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // an arriving byte always beats a simultaneous expiry
                if (i_rx_valid) begin
                    w_store = 1'b1;
                    if (w_last) begin
`ifdef UART_FRAME_CSUM_EN
                        w_state_nxt = ST_CSUM;
`else
                        w_state_nxt = ST_HOLD;
`endif
                    end
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
                end
            end
`ifdef UART_FRAME_CSUM_EN
            ST_CSUM: begin
                if (i_rx_valid) begin
                    if (i_rx_data == r_sum) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_csum_bad  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
                end
            end
`endif
            ST_HOLD: begin
                w_drop = i_rx_valid;
                if (i_frm_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_idx         <= '0;
            r_tmo_cnt     <= '0;
            r_frm_data    <= '0;
            r_drop_cnt    <= 8'd0;
            r_err_timeout <= 1'b0;
            r_err_csum    <= 1'b0;
        end else begin
            r_tmo_cnt     <= w_tmo_nxt;
            r_err_timeout <= w_timeout;
            r_err_csum    <= w_csum_bad;
            if (w_store) begin
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            end else if (w_timeout) begin
                r_idx <= '0;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (w_store && (r_idx == IDX_W'(k))) begin
                    r_frm_data[k*WIDTH +: WIDTH] <= i_rx_data;
                end
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

`ifdef UART_FRAME_CSUM_EN
    // running sum restarts every time the hunt restarts
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_sum <= '0;
        end else if (r_state == ST_IDLE) begin
            r_sum <= '0;
        end else if (w_store) begin
            r_sum <= r_sum + i_rx_data;
        end
    end
    assign o_err_csum = r_err_csum;
`else
    assign o_err_csum = 1'b0;
`endif

    assign o_frm_valid   = (r_state == ST_HOLD);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_frm_data    = r_frm_data;
    assign o_err_timeout = r_err_timeout;
    assign o_drop_cnt    = r_drop_cnt;

endmodule
